// File: rtl/ntt_pkg.sv
// Shared NTT constants and the Montgomery-encode FSM state type.
package ntt_pkg;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned RBITS   = 23;
  localparam int unsigned Q       = 8380417;
  localparam int unsigned R_MOD_Q = 8191;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;
endpackage

// File: rtl/mont_encode_mod_dbl_add.sv
// Combinational modular double-and-add: res = (2*acc + bit_in) mod q, valid for acc < q.
module mod_dbl_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] res
);
  logic [WIDTH:0] t;
  logic [WIDTH:0] qx;
  logic [WIDTH:0] d;

  always_comb begin
    t   = {acc, bit_in};
    qx  = {1'b0, q};
    d   = t - qx;
    res = (t >= qx) ? d[WIDTH-1:0] : t[WIDTH-1:0];
  end
endmodule

// File: rtl/mont_encode.sv
// Bit-serial conversion into Montgomery form: R_out = (A * 2^RBITS) mod Q.
module mont_encode
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = ntt_pkg::WIDTH,
  parameter int unsigned Q     = ntt_pkg::Q,
  parameter int unsigned RBITS = ntt_pkg::RBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R_out
);
  localparam logic [WIDTH-1:0] QV       = WIDTH'(Q);
  localparam logic [CNT_W-1:0] CNT_PH1  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH + RBITS - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_nxt;
  logic             step_bit;

  // Horner phase feeds A's MSB; the doubling phase forces the bit to zero.
  assign step_bit = (cnt < CNT_PH1) ? sh[WIDTH-1] : 1'b0;

  mod_dbl_add #(.WIDTH(WIDTH)) u_step (
    .acc    (acc),
    .bit_in (step_bit),
    .q      (QV),
    .res    (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      sh        <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      R_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            sh       <= A;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (cnt < CNT_PH1) sh <= sh << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            R_out     <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
